decode_stage: RTL and testbench

Parametrised, pipelined RV64I(M) instruction decode stage that replaces the display-only decoder in the fetch→execute path. Accepts one 32-bit instruction plus PC per cycle over a valid/ready handshake. Registers fully decoded fields (register indices, sign-extended immediate, ALU op, class, illegal flag) toward execute through a 2-entry skid buffer, so `in_ready` is registered and never depends combinationally on `out_ready`.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/imm_gen.sv | 24 ++
 rtl/decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_decode_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64I(M) decode types, opcode map and width defaults
package riscv_pkg;
  localparam int INSTRSZ_DEFAULT = 32;
  localparam int REGBITS_DEFAULT = 5;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_IMM32  = 7'b0011011,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_OP32   = 7'b0111011,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;
  typedef enum logic [3:0] {
    OPC_ALU, OPC_ALUW, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MULDIV
  } opclass_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
  function automatic alu_op_t base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  // M-extension ops are laid out in funct3 order starting at ALU_MUL
  function automatic alu_op_t mul_op(input logic [2:0] f3);
    return alu_op_t'(5'(ALU_MUL) + {2'b00, f3});
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for the I/S/B/U/J formats, zero for R
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int INSTRSZ = INSTRSZ_DEFAULT
) (
  input  logic [INSTRSZ-1:0] instr,
  input  imm_type_t          imm_type,
  output logic [XLEN-1:0]    imm
);
  logic [31:0] v;
  logic unused_bits;
  assign unused_bits = ^instr[6:0];
  always_comb begin
    v = imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
        imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
        imm_type == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
        imm_type == IMM_U ? {instr[31:12], 12'b0} :
        imm_type == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
        32'd0;
    imm = XLEN'($signed(v));
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipelined RV64I(M) decoder feeding execute through a 2-entry skid buffer
// RV_M_EXT_EN enables MUL/DIV decoding; otherwise those encodings are illegal.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int INSTRSZ = INSTRSZ_DEFAULT,
  parameter int REGBITS = REGBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTRSZ-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [REGBITS-1:0] out_rs1,
  output logic [REGBITS-1:0] out_rs2,
  output logic [REGBITS-1:0] out_rd,
  output logic [XLEN-1:0]    out_imm,
  output alu_op_t            out_alu_op,
  output opclass_t           out_opclass,
  output logic [2:0]         out_funct3,
  output logic               out_uses_rs1,
  output logic               out_uses_rs2,
  output logic               out_writes_rd,
  output logic               out_illegal
);
`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  localparam bit RV64 = XLEN == 64;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [REGBITS-1:0] rs1;
    logic [REGBITS-1:0] rs2;
    logic [REGBITS-1:0] rd;
    logic [XLEN-1:0]    imm;
    alu_op_t            alu_op;
    opclass_t           opclass;
    logic [2:0]         funct3;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic               illegal;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic ill, u1, u2, wr, w;
  opclass_t cls;
  alu_op_t op;
  imm_type_t it;
  logic [XLEN-1:0] imm;
  entry_t dec, out_q, skid_q;
  state_t state, state_n;
  logic accept, pop;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign w = opc == OP_OP32;
  always_comb begin
    ill = 1'b0;
    cls = OPC_ALU;
    op = ALU_ADD;
    it = IMM_NONE;
    u1 = 1'b1;
    u2 = 1'b0;
    wr = 1'b1;
    case (opc)
      OP_LUI: begin
        cls = OPC_LUI;
        it = IMM_U;
        u1 = 1'b0;
      end
      OP_AUIPC: begin
        cls = OPC_AUIPC;
        it = IMM_U;
        u1 = 1'b0;
      end
      OP_JAL: begin
        cls = OPC_JAL;
        it = IMM_J;
        u1 = 1'b0;
      end
      OP_JALR: begin
        cls = OPC_JALR;
        it = IMM_I;
        ill = f3 != 3'b000;
      end
      OP_BRANCH: begin
        cls = OPC_BRANCH;
        it = IMM_B;
        u2 = 1'b1;
        wr = 1'b0;
        ill = f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        cls = OPC_LOAD;
        it = IMM_I;
        ill = f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OP_STORE: begin
        cls = OPC_STORE;
        it = IMM_S;
        u2 = 1'b1;
        wr = 1'b0;
        ill = f3[2] || (!RV64 && f3 == 3'b011);
      end
      OP_IMM: begin
        it = IMM_I;
        op = f3 == 3'b101 && in_instr[30] ? ALU_SRA : base_op(f3);
        // 6-bit shamt: only funct6 is checked, bit 25 belongs to the shift amount
        ill = (f3 == 3'b001 && in_instr[31:26] != 6'b000000) ||
              (f3 == 3'b101 && in_instr[31:26] != 6'b000000 && in_instr[31:26] != 6'b010000);
      end
      OP_IMM32: begin
        cls = OPC_ALUW;
        it = IMM_I;
        op = f3 == 3'b101 && in_instr[30] ? ALU_SRA : base_op(f3);
        ill = !RV64 || !(f3 == 3'b000 || (f3 == 3'b001 && f7 == 7'b0000000) ||
              (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)));
      end
      OP_OP, OP_OP32: begin
        u2 = 1'b1;
        if (f7 == 7'b0000001) begin
          cls = OPC_MULDIV;
          op = mul_op(f3);
          ill = !M_EN || (w && (!RV64 || f3 inside {3'b001, 3'b010, 3'b011}));
        end else begin
          cls = w ? OPC_ALUW : OPC_ALU;
          op = f7[5] ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : base_op(f3);
          ill = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) ||
                (w && (!RV64 || !(f3 inside {3'b000, 3'b001, 3'b101})));
        end
      end
      default: ill = 1'b1;
    endcase
  end
  imm_gen #(.XLEN(XLEN), .INSTRSZ(INSTRSZ)) u_imm (.instr(in_instr), .imm_type(it), .imm(imm));
  assign dec = '{
    pc: in_pc,
    rs1: REGBITS'(in_instr[19:15]),
    rs2: REGBITS'(in_instr[24:20]),
    rd: REGBITS'(in_instr[11:7]),
    imm: imm,
    alu_op: op,
    opclass: cls,
    funct3: f3,
    uses_rs1: u1,
    uses_rs2: u2,
    writes_rd: wr && !ill && in_instr[11:7] != 5'd0,
    illegal: ill
  };
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   state_n = accept ? ONE : EMPTY;
      ONE:     state_n = accept && !pop ? FULL : !accept && pop ? EMPTY : ONE;
      FULL:    state_n = pop ? ONE : FULL;
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      if (!flush && accept && (state == EMPTY || pop)) out_q <= dec;
      else if (!flush && state == FULL && pop) out_q <= skid_q;
      if (!flush && accept && state == ONE && !pop) skid_q <= dec;
    end
  end
  assign out_pc = out_q.pc;
  assign out_rs1 = out_q.rs1;
  assign out_rs2 = out_q.rs2;
  assign out_rd = out_q.rd;
  assign out_imm = out_q.imm;
  assign out_alu_op = out_q.alu_op;
  assign out_opclass = out_q.opclass;
  assign out_funct3 = out_q.funct3;
  assign out_uses_rs1 = out_q.uses_rs1;
  assign out_uses_rs2 = out_q.uses_rs2;
  assign out_writes_rd = out_q.writes_rd;
  assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + random checks of decode_stage against a mask/match opcode table model
module tb_decode_stage;
  import riscv_pkg::*;
`ifdef RV_M_EXT_EN
  localparam bit M_ON = 1'b1;
`else
  localparam bit M_ON = 1'b0;
`endif
  localparam logic [31:0] M_OP = 32'h0000007F, M_F3 = 32'h0000707F, M_F7 = 32'hFE00707F, M_F6 = 32'hFC00707F;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd;
  alu_op_t out_alu_op;
  opclass_t out_opclass;
  logic [2:0] out_funct3;
  logic out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  decode_stage #(.XLEN(64), .INSTRSZ(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_opclass(out_opclass), .out_funct3(out_funct3),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2), .out_writes_rd(out_writes_rd),
    .out_illegal(out_illegal)
  );
  typedef struct {
    logic [31:0] mask, match;
    opclass_t cls;
    alu_op_t op;
    imm_type_t it;
  } pat_t;
  typedef struct {
    logic [63:0] pc, imm;
    logic [4:0] rs1, rs2, rd;
    alu_op_t op;
    opclass_t cls;
    logic [2:0] f3;
    logic u1, u2, wr, ill;
  } exp_t;
  pat_t pats[$];
  exp_t q[$];
  alu_op_t base[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  alu_op_t mul[8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  task automatic add(input logic [31:0] mask, input logic [6:0] op7, input int f3, input logic [6:0] f7,
                     input opclass_t cls, input alu_op_t op, input imm_type_t it);
    pat_t p;
    p.mask = mask;
    p.match = ({f7, 25'd0} | (32'(f3) << 12) | {25'd0, op7}) & mask;
    p.cls = cls;
    p.op = op;
    p.it = it;
    pats.push_back(p);
  endtask
  task automatic build_table();
    add(M_OP, 7'h37, 0, 0, OPC_LUI, ALU_ADD, IMM_U);
    add(M_OP, 7'h17, 0, 0, OPC_AUIPC, ALU_ADD, IMM_U);
    add(M_OP, 7'h6F, 0, 0, OPC_JAL, ALU_ADD, IMM_J);
    add(M_F3, 7'h67, 0, 0, OPC_JALR, ALU_ADD, IMM_I);
    for (int f = 0; f < 8; f++) if (f != 2 && f != 3) add(M_F3, 7'h63, f, 0, OPC_BRANCH, ALU_ADD, IMM_B);
    for (int f = 0; f < 7; f++) add(M_F3, 7'h03, f, 0, OPC_LOAD, ALU_ADD, IMM_I);
    for (int f = 0; f < 4; f++) add(M_F3, 7'h23, f, 0, OPC_STORE, ALU_ADD, IMM_S);
    for (int f = 0; f < 8; f++) if (f != 1 && f != 5) add(M_F3, 7'h13, f, 0, OPC_ALU, base[f], IMM_I);
    add(M_F6, 7'h13, 1, 7'h00, OPC_ALU, ALU_SLL, IMM_I);
    add(M_F6, 7'h13, 5, 7'h00, OPC_ALU, ALU_SRL, IMM_I);
    add(M_F6, 7'h13, 5, 7'h20, OPC_ALU, ALU_SRA, IMM_I);
    for (int f = 0; f < 8; f++) add(M_F7, 7'h33, f, 7'h00, OPC_ALU, base[f], IMM_NONE);
    add(M_F7, 7'h33, 0, 7'h20, OPC_ALU, ALU_SUB, IMM_NONE);
    add(M_F7, 7'h33, 5, 7'h20, OPC_ALU, ALU_SRA, IMM_NONE);
    add(M_F3, 7'h1B, 0, 7'h00, OPC_ALUW, ALU_ADD, IMM_I);
    add(M_F7, 7'h1B, 1, 7'h00, OPC_ALUW, ALU_SLL, IMM_I);
    add(M_F7, 7'h1B, 5, 7'h00, OPC_ALUW, ALU_SRL, IMM_I);
    add(M_F7, 7'h1B, 5, 7'h20, OPC_ALUW, ALU_SRA, IMM_I);
    add(M_F7, 7'h3B, 0, 7'h00, OPC_ALUW, ALU_ADD, IMM_NONE);
    add(M_F7, 7'h3B, 1, 7'h00, OPC_ALUW, ALU_SLL, IMM_NONE);
    add(M_F7, 7'h3B, 5, 7'h00, OPC_ALUW, ALU_SRL, IMM_NONE);
    add(M_F7, 7'h3B, 0, 7'h20, OPC_ALUW, ALU_SUB, IMM_NONE);
    add(M_F7, 7'h3B, 5, 7'h20, OPC_ALUW, ALU_SRA, IMM_NONE);
`ifdef RV_M_EXT_EN
    for (int f = 0; f < 8; f++) add(M_F7, 7'h33, f, 7'h01, OPC_MULDIV, mul[f], IMM_NONE);
    for (int f = 0; f < 8; f++) if (f == 0 || f >= 4) add(M_F7, 7'h3B, f, 7'h01, OPC_MULDIV, mul[f], IMM_NONE);
`endif
  endtask
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
    exp_t e;
    int hit = -1;
    imm_type_t it;
    for (int k = 0; k < pats.size(); k++) if (hit < 0 && (i & pats[k].mask) == pats[k].match) hit = k;
    e.pc = pc;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.f3 = i[14:12];
    e.ill = hit < 0;
    e.cls = OPC_ALU;
    e.op = ALU_ADD;
    e.imm = 64'd0;
    e.u1 = 1'b0;
    e.u2 = 1'b0;
    e.wr = 1'b0;
    if (hit >= 0) begin
      e.cls = pats[hit].cls;
      e.op = pats[hit].op;
      it = pats[hit].it;
      case (it)
        IMM_I:   e.imm = 64'($signed(i[31:20]));
        IMM_S:   e.imm = 64'($signed({i[31:25], i[11:7]}));
        IMM_B:   e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        IMM_U:   e.imm = 64'($signed({i[31:12], 12'h000}));
        IMM_J:   e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        default: e.imm = 64'd0;
      endcase
      e.u1 = !(it inside {IMM_U, IMM_J});
      e.u2 = it inside {IMM_NONE, IMM_S, IMM_B};
      e.wr = !(it inside {IMM_S, IMM_B}) && i[11:7] != 5'd0;
    end
    return e;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cmp(input exp_t e);
    chk("pc", out_pc, e.pc);
    chk("illegal", out_illegal, e.ill);
    chk("writes_rd", out_writes_rd, e.wr);
    if (!e.ill) begin
      chk("rs1", out_rs1, e.rs1);
      chk("rs2", out_rs2, e.rs2);
      chk("rd", out_rd, e.rd);
      chk("imm", out_imm, e.imm);
      chk("alu_op", out_alu_op, e.op);
      chk("opclass", out_opclass, e.cls);
      chk("funct3", out_funct3, e.f3);
      chk("uses_rs1", out_uses_rs1, e.u1);
      chk("uses_rs2", out_uses_rs2, e.u2);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl, input logic rs);
    int n;
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    reset = rs;
    n = q.size();
    chk("out_valid", out_valid, n != 0);
    chk("in_ready", in_ready, n < 2);
    if (fl || rs) q.delete();
    else begin
      if (ordy && n > 0) begin
        cmp(q[0]);
        void'(q.pop_front());
      end
      if (v && n < 2) q.push_back(model(ins, pc));
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[11] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F};
    logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    r[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 2) != 0) r[31:25] = f7s[$urandom_range(0, 2)];
    if ($urandom_range(0, 3) == 0) r[31:26] = 6'b000000;
    return r;
  endfunction
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'd0;
    in_pc = 64'd0;
    out_ready = 1'b0;
    build_table();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_rd", out_rd, 5'd0);
    chk("rst_alu_op", out_alu_op, ALU_ADD);
    chk("rst_opclass", out_opclass, OPC_ALU);
    chk("rst_illegal", out_illegal, 1'b0);
    chk("rst_writes_rd", out_writes_rd, 1'b0);
    step(1, 32'hFFF00093, 64'h1000, 1, 0, 0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_rs1", out_rs1, 5'd0);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_op", out_alu_op, ALU_ADD);
    chk("addi_wr", out_writes_rd, 1'b1);
    chk("addi_ill", out_illegal, 1'b0);
    step(1, 32'hFE208CE3, 64'h1004, 1, 0, 0);
    chk("beq_cls", out_opclass, OPC_BRANCH);
    chk("beq_rs1", out_rs1, 5'd1);
    chk("beq_rs2", out_rs2, 5'd2);
    chk("beq_imm", out_imm, -64'sd8);
    chk("beq_f3", out_funct3, 3'd0);
    chk("beq_wr", out_writes_rd, 1'b0);
    step(1, 32'h022081B3, 64'h1008, 1, 0, 0);
    chk("mul_ill", out_illegal, !M_ON);
`ifdef RV_M_EXT_EN
    chk("mul_cls", out_opclass, OPC_MULDIV);
    chk("mul_op", out_alu_op, ALU_MUL);
`endif
    step(1, 32'h00000000, 64'h100C, 1, 0, 0);
    chk("zero_ill", out_illegal, 1'b1);
    chk("zero_wr", out_writes_rd, 1'b0);
    step(1, 32'h03F09093, 64'h1010, 1, 0, 0);
    chk("slli_ill", out_illegal, 1'b0);
    chk("slli_shamt", out_imm[5:0], 6'd63);
    step(1, 32'h0200909B, 64'h1014, 1, 0, 0);
    chk("slliw_ill", out_illegal, 1'b1);
    step(0, 32'd0, 64'd0, 1, 0, 0);
    step(1, 32'h00100093, 64'h2000, 0, 0, 0);
    step(1, 32'h00200113, 64'h2004, 0, 0, 0);
    chk("bp_full", in_ready, 1'b0);
    step(1, 32'h00300193, 64'h2008, 0, 0, 0);
    chk("bp_stall_ready", in_ready, 1'b0);
    chk("bp_stall_pc", out_pc, 64'h2000);
    step(1, 32'h00300193, 64'h2008, 1, 0, 0);
    chk("bp_pop1_pc", out_pc, 64'h2004);
    step(1, 32'h00300193, 64'h2008, 1, 0, 0);
    step(0, 32'd0, 64'd0, 1, 0, 0);
    step(0, 32'd0, 64'd0, 1, 0, 0);
    step(1, 32'h00100093, 64'h3000, 0, 0, 0);
    step(1, 32'h00200113, 64'h3004, 0, 1, 0);
    chk("flush1_valid", out_valid, 1'b0);
    chk("flush1_ready", in_ready, 1'b1);
    step(0, 32'd0, 64'd0, 1, 0, 0);
    step(1, 32'h00100093, 64'h4000, 0, 0, 0);
    step(1, 32'h00200113, 64'h4004, 0, 0, 0);
    step(1, 32'h00300193, 64'h4008, 1, 1, 0);
    chk("flush2_valid", out_valid, 1'b0);
    chk("flush2_ready", in_ready, 1'b1);
    step(1, 32'h00400213, 64'h400C, 1, 0, 0);
    step(1, 32'h00100093, 64'h5000, 0, 0, 0);
    step(1, 32'h00200113, 64'h5004, 0, 0, 0);
    step(1, 32'h00300193, 64'h5008, 1, 0, 1);
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_ready", in_ready, 1'b1);
    chk("rst2_pc", out_pc, 64'd0);
    step(0, 32'd0, 64'd0, 1, 0, 0);
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom}, $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    for (int n = 0; n < 4; n++) step(0, 32'd0, 64'd0, 1, 0, 0);
    chk("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
